// File: rtl/raster_pkg.sv
// Shared types and widths for the segment rasterizer datapath.
package raster_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    STEP,
    DONE
  } state_e;

  localparam int COORD_X_W = 11;
  localparam int COORD_Y_W = 10;
  localparam int ERR_W     = 13;

endpackage

// File: rtl/segment_rasterizer.sv
// Integer Bresenham walker: holds one segment, emits one on-screen pixel per handshake,
// skips off-screen pixels at one per cycle, and pulses done after the endpoint resolves.
//
//   state | meaning
//   IDLE  | waiting for a segment; busy low
//   SETUP | derive dx/dy/err/step directions from latched endpoints
//   STEP  | present or skip the current pixel, advance on handshake or clip
//   DONE  | one-cycle completion pulse
module segment_rasterizer
  import raster_pkg::*;
#(
  parameter int H_RES = 1280,
  parameter int V_RES = 720
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 seg_valid_in,
  input  logic [COORD_X_W-1:0] x_in_1,
  input  logic [COORD_Y_W-1:0] y_in_1,
  input  logic [COORD_X_W-1:0] x_in_2,
  input  logic [COORD_Y_W-1:0] y_in_2,
  input  logic                 is_static_in,
  output logic                 busy_out,
  output logic [COORD_X_W-1:0] pixel_x_out,
  output logic [COORD_Y_W-1:0] pixel_y_out,
  output logic                 pixel_static_out,
  output logic                 pixel_valid_out,
  input  logic                 pixel_ready_in,
  output logic                 done_out
);

  localparam logic [COORD_X_W:0]   H_LIM = (COORD_X_W+1)'(H_RES);
  localparam logic [COORD_Y_W:0]   V_LIM = (COORD_Y_W+1)'(V_RES);
  localparam logic [COORD_X_W-1:0] X_ONE = COORD_X_W'(1);
  localparam logic [COORD_Y_W-1:0] Y_ONE = COORD_Y_W'(1);

  state_e state_q, state_d;

  logic [COORD_X_W-1:0] cur_x_q, cur_x_d, end_x_q, end_x_d;
  logic [COORD_Y_W-1:0] cur_y_q, cur_y_d, end_y_q, end_y_d;
  logic                 static_q, static_d;
  logic                 sx_neg_q, sx_neg_d, sy_neg_q, sy_neg_d;

  logic signed [ERR_W-1:0] dx_q, dx_d, dy_q, dy_d, err_q, err_d, err_n;
  logic signed [ERR_W:0]   e2, dx_w, dy_w;

  logic [COORD_X_W-1:0] mag_x;
  logic [COORD_Y_W-1:0] mag_y;
  logic                 on_screen, at_end, adv;

  always_comb begin
    state_d  = state_q;
    cur_x_d  = cur_x_q;
    cur_y_d  = cur_y_q;
    end_x_d  = end_x_q;
    end_y_d  = end_y_q;
    static_d = static_q;
    sx_neg_d = sx_neg_q;
    sy_neg_d = sy_neg_q;
    dx_d     = dx_q;
    dy_d     = dy_q;
    err_d    = err_q;

    on_screen = ({1'b0, cur_x_q} < H_LIM) && ({1'b0, cur_y_q} < V_LIM);
    at_end    = (cur_x_q == end_x_q) && (cur_y_q == end_y_q);
    adv       = !on_screen || pixel_ready_in;

    e2    = {err_q, 1'b0};
    dx_w  = {dx_q[ERR_W-1], dx_q};
    dy_w  = {dy_q[ERR_W-1], dy_q};
    err_n = err_q;

    mag_x = (end_x_q >= cur_x_q) ? end_x_q - cur_x_q : cur_x_q - end_x_q;
    mag_y = (end_y_q >= cur_y_q) ? end_y_q - cur_y_q : cur_y_q - end_y_q;

    case (state_q)
      IDLE: begin
        if (seg_valid_in) begin
          cur_x_d  = x_in_1;
          cur_y_d  = y_in_1;
          end_x_d  = x_in_2;
          end_y_d  = y_in_2;
          static_d = is_static_in;
          state_d  = SETUP;
        end
      end
      SETUP: begin
        // cur still holds the start point here, so magnitudes come straight from cur/end
        dx_d     = $signed({{(ERR_W-COORD_X_W){1'b0}}, mag_x});
        dy_d     = -$signed({{(ERR_W-COORD_Y_W){1'b0}}, mag_y});
        err_d    = dx_d + dy_d;
        sx_neg_d = end_x_q < cur_x_q;
        sy_neg_d = end_y_q < cur_y_q;
        state_d  = STEP;
      end
      STEP: begin
        if (adv) begin
          if (at_end) begin
            state_d = DONE;
          end else begin
            if (e2 >= dy_w) begin
              err_n   = err_n + dy_q;
              cur_x_d = sx_neg_q ? cur_x_q - X_ONE : cur_x_q + X_ONE;
            end
            if (e2 <= dx_w) begin
              err_n   = err_n + dx_q;
              cur_y_d = sy_neg_q ? cur_y_q - Y_ONE : cur_y_q + Y_ONE;
            end
            err_d = err_n;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q  <= IDLE;
      cur_x_q  <= '0;
      cur_y_q  <= '0;
      end_x_q  <= '0;
      end_y_q  <= '0;
      static_q <= 1'b0;
      sx_neg_q <= 1'b0;
      sy_neg_q <= 1'b0;
      dx_q     <= '0;
      dy_q     <= '0;
      err_q    <= '0;
    end else begin
      state_q  <= state_d;
      cur_x_q  <= cur_x_d;
      cur_y_q  <= cur_y_d;
      end_x_q  <= end_x_d;
      end_y_q  <= end_y_d;
      static_q <= static_d;
      sx_neg_q <= sx_neg_d;
      sy_neg_q <= sy_neg_d;
      dx_q     <= dx_d;
      dy_q     <= dy_d;
      err_q    <= err_d;
    end
  end

  assign busy_out         = (state_q == SETUP) || (state_q == STEP);
  assign pixel_valid_out  = (state_q == STEP) && on_screen;
  assign done_out         = (state_q == DONE);
  assign pixel_x_out      = cur_x_q;
  assign pixel_y_out      = cur_y_q;
  assign pixel_static_out = static_q;

endmodule
